// File: rtl/frogger_game_seq.sv
// rtl/frogger_game_seq.sv - Frogger round lifecycle sequencer: lives, score, death/goal pauses, respawn.
// Optional round timer is built when FROGGER_ROUND_TIMER_EN is defined.
module frogger_game_seq #(
  parameter int unsigned c_LIVES         = 3,
  parameter int unsigned c_DEATH_CYCLES  = 25000000,
  parameter int unsigned c_GOAL_CYCLES   = 12500000,
  parameter int unsigned c_SECOND_CYCLES = 25000000,
  parameter int unsigned c_ROUND_SECONDS = 30,
  parameter int unsigned c_SCORE_MAX     = 99,
  parameter int unsigned c_BLINK_BIT     = 22
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Collided,
  input  logic       i_In_Water,
  input  logic       i_Goal,
  output logic [2:0] o_State,
  output logic       o_Move_En,
  output logic       o_Respawn,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic [5:0] o_Time_Left,
  output logic       o_Blink,
  output logic       o_Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DEATH = 3'd2,
    S_GOAL  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [1:0]  LP_LIVES      = 2'(c_LIVES);
  localparam logic [6:0]  LP_SCORE_MAX  = 7'(c_SCORE_MAX);
  localparam logic [24:0] LP_DEATH_LAST = 25'(c_DEATH_CYCLES - 1);
  localparam logic [24:0] LP_GOAL_LAST  = 25'(c_GOAL_CYCLES - 1);

  state_t      state_q;
  logic        move_en_q;
  logic        respawn_q;
  logic [1:0]  lives_q;
  logic [6:0]  score_q;
  logic [5:0]  time_left_q;
  logic        blink_q;
  logic        game_over_q;
  logic [24:0] pause_cnt_q;
  logic [24:0] pause_cnt_d;
  logic        start_prev_q;
  logic        start_edge_q;
  logic        sec_wrap;
  logic        timer_expired;
  logic        death_evt;

`ifdef FROGGER_ROUND_TIMER_EN
  localparam logic [5:0]  LP_ROUND    = 6'(c_ROUND_SECONDS);
  localparam logic [24:0] LP_SEC_LAST = 25'(c_SECOND_CYCLES - 1);

  logic [24:0] sec_cnt_q;

  // Held at zero outside PLAY, so every entry to PLAY starts a fresh second.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sec_cnt_q <= '0;
    end else if (state_q != S_PLAY || sec_wrap) begin
      sec_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_q + 25'd1;
    end
  end

  assign sec_wrap      = (state_q == S_PLAY) && (sec_cnt_q == LP_SEC_LAST);
  assign timer_expired = (state_q == S_PLAY) && (time_left_q == 6'd0);
`else
  localparam logic [5:0]  LP_ROUND    = 6'd0;

  assign sec_wrap      = 1'b0;
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    pause_cnt_d = pause_cnt_q + 25'd1;
    death_evt   = i_Collided | i_In_Water | timer_expired;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      move_en_q    <= 1'b0;
      respawn_q    <= 1'b0;
      lives_q      <= 2'd0;
      score_q      <= 7'd0;
      time_left_q  <= 6'd0;
      blink_q      <= 1'b0;
      game_over_q  <= 1'b0;
      pause_cnt_q  <= '0;
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      start_prev_q <= i_Start;
      start_edge_q <= i_Start & ~start_prev_q;
      respawn_q    <= 1'b0;
      blink_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_edge_q) begin
            lives_q     <= LP_LIVES;
            score_q     <= 7'd0;
            time_left_q <= LP_ROUND;
            respawn_q   <= 1'b1;
            move_en_q   <= 1'b1;
            game_over_q <= 1'b0;
            state_q     <= S_PLAY;
          end
        end
        S_PLAY: begin
          // Death outranks a simultaneous goal; the score is then left alone.
          if (death_evt) begin
            if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
            pause_cnt_q <= '0;
            move_en_q   <= 1'b0;
            state_q     <= S_DEATH;
          end else if (i_Goal) begin
            if (score_q < LP_SCORE_MAX) score_q <= score_q + 7'd1;
            pause_cnt_q <= '0;
            move_en_q   <= 1'b0;
            state_q     <= S_GOAL;
          end else if (sec_wrap && time_left_q != 6'd0) begin
            time_left_q <= time_left_q - 6'd1;
          end
        end
        S_DEATH: begin
          if (pause_cnt_q == LP_DEATH_LAST) begin
            if (lives_q == 2'd0) begin
              game_over_q <= 1'b1;
              state_q     <= S_OVER;
            end else begin
              time_left_q <= LP_ROUND;
              respawn_q   <= 1'b1;
              move_en_q   <= 1'b1;
              state_q     <= S_PLAY;
            end
          end else begin
            pause_cnt_q <= pause_cnt_d;
            blink_q     <= pause_cnt_d[c_BLINK_BIT];
          end
        end
        S_GOAL: begin
          if (pause_cnt_q == LP_GOAL_LAST) begin
            time_left_q <= LP_ROUND;
            respawn_q   <= 1'b1;
            move_en_q   <= 1'b1;
            state_q     <= S_PLAY;
          end else begin
            pause_cnt_q <= pause_cnt_d;
          end
        end
        default: begin
          move_en_q   <= 1'b0;
          game_over_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_State     = state_q;
  assign o_Move_En   = move_en_q;
  assign o_Respawn   = respawn_q;
  assign o_Lives     = lives_q;
  assign o_Score     = score_q;
  assign o_Time_Left = time_left_q;
  assign o_Blink     = blink_q;
  assign o_Game_Over = game_over_q;

endmodule

// File: tb/tb_frogger_game_seq.sv
// tb/tb_frogger_game_seq.sv - Scoreboard bench for frogger_game_seq against a round-level reference model.
`timescale 1ns/1ps
module tb_frogger_game_seq;

  localparam int D_CYC   = 8;
  localparam int G_CYC   = 4;
  localparam int SEC_CYC = 10;
  localparam int ROUND_S = 3;
  localparam int BLINK_B = 1;
  localparam int LIVES   = 3;
  localparam int SMAX    = 99;
`ifdef FROGGER_ROUND_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Collided = 1'b0;
  logic       i_In_Water = 1'b0;
  logic       i_Goal = 1'b0;
  logic [2:0] o_State;
  logic       o_Move_En;
  logic       o_Respawn;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [5:0] o_Time_Left;
  logic       o_Blink;
  logic       o_Game_Over;

  frogger_game_seq #(
    .c_LIVES(LIVES), .c_DEATH_CYCLES(D_CYC), .c_GOAL_CYCLES(G_CYC),
    .c_SECOND_CYCLES(SEC_CYC), .c_ROUND_SECONDS(ROUND_S),
    .c_SCORE_MAX(SMAX), .c_BLINK_BIT(BLINK_B)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start),
    .i_Collided(i_Collided), .i_In_Water(i_In_Water), .i_Goal(i_Goal),
    .o_State(o_State), .o_Move_En(o_Move_En), .o_Respawn(o_Respawn),
    .o_Lives(o_Lives), .o_Score(o_Score), .o_Time_Left(o_Time_Left),
    .o_Blink(o_Blink), .o_Game_Over(o_Game_Over)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int state; int move_en; int respawn; int lives;
    int score; int time_left; int blink; int game_over;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Round-level model: game phase, lives, score, seconds left, clocks left in a pause.
  int m_mode, m_lives, m_score, m_tl, m_remain, m_sec, s1, s2, m_respawn;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lives = 0; m_score = 0; m_tl = 0;
    m_remain = 0; m_sec = 0; s1 = 0; s2 = 0; m_respawn = 0;
  endtask

  task automatic begin_round();
    m_mode = 1; m_respawn = 1; m_sec = 0;
    m_tl = TIMER_EN ? ROUND_S : 0;
  endtask

  task automatic model_edge(input bit st, input bit col, input bit wat, input bit gl);
    bit go;
    go = (s1 == 1) && (s2 == 0);
    s2 = s1; s1 = st; m_respawn = 0;
    case (m_mode)
      0, 4: if (go) begin
        m_lives = LIVES; m_score = 0; begin_round();
      end
      1: begin
        if (col || wat || (TIMER_EN && m_tl == 0)) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_mode = 2; m_remain = D_CYC;
        end else if (gl) begin
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          m_mode = 3; m_remain = G_CYC;
        end else if (TIMER_EN) begin
          m_sec++;
          if (m_sec == SEC_CYC) begin
            m_sec = 0;
            if (m_tl > 0) m_tl--;
          end
        end
      end
      2, 3: begin
        m_remain--;
        if (m_remain == 0) begin
          if (m_mode == 2 && m_lives == 0) m_mode = 4;
          else begin_round();
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.state     = m_mode;
    e.move_en   = (m_mode == 1);
    e.respawn   = m_respawn;
    e.lives     = m_lives;
    e.score     = m_score;
    e.time_left = m_tl;
    e.blink     = (m_mode == 2) ? ((D_CYC - m_remain) / (1 << BLINK_B)) % 2 : 0;
    e.game_over = (m_mode == 4);
    return e;
  endfunction

  task automatic step(input bit st, input bit col, input bit wat, input bit gl);
    @(negedge i_Clk);
    i_Start = st; i_Collided = col; i_In_Water = wat; i_Goal = gl;
    if (i_Rst_L) model_edge(st, col, wat, gl);
    else model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic ensure_play();
    for (int k = 0; k < 60 && m_mode != 1; k++) step(k % 2, 0, 0, 0);
    if (m_mode != 1) begin
      vectors++; miscompares++;
      $display("FAIL ensure_play: phase %0d, expected 1", m_mode);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",     int'(o_State),     e.state);
        chk("move_en",   int'(o_Move_En),   e.move_en);
        chk("respawn",   int'(o_Respawn),   e.respawn);
        chk("lives",     int'(o_Lives),     e.lives);
        chk("score",     int'(o_Score),     e.score);
        chk("time_left", int'(o_Time_Left), e.time_left);
        chk("blink",     int'(o_Blink),     e.blink);
        chk("game_over", int'(o_Game_Over), e.game_over);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    idle(3);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    idle(2);

    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1);
    idle(6);
    step(0, 1, 0, 1);
    idle(10);

    ensure_play();
    for (int g = 0; g < 104; g++) begin
      step(0, 0, 0, 1);
      idle(5);
    end

    for (int d = 0; d < 3; d++) begin
      ensure_play();
      step(0, 1, 0, 0);
      idle(9);
    end
    idle(3);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    idle(40);

    for (int r = 0; r < 1500; r++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0);

    ensure_play();
    step(0, 0, 1, 0);
    idle(3);
    @(negedge i_Clk);
    i_Start = 0; i_Collided = 0; i_In_Water = 0; i_Goal = 0;
    model_reset();
    exp_q.push_back(model_out());
    #2 i_Rst_L = 1'b0;
    #1;
    chk("async_state",     int'(o_State),     0);
    chk("async_move_en",   int'(o_Move_En),   0);
    chk("async_respawn",   int'(o_Respawn),   0);
    chk("async_lives",     int'(o_Lives),     0);
    chk("async_score",     int'(o_Score),     0);
    chk("async_time_left", int'(o_Time_Left), 0);
    chk("async_blink",     int'(o_Blink),     0);
    chk("async_game_over", int'(o_Game_Over), 0);
    idle(2);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    step(0, 1, 1, 1); step(0, 0, 0, 1); step(0, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(6);

    repeat (2) @(posedge i_Clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frogger_game_seq.md
# frogger_game_seq

Game-level sequencer for the Frogger design. Sits above the frog movement controller and the sprite/scene renderers, and owns the round lifecycle:
- start, play, death pause, goal pause and game over;
- the lives count, the score and the optional round timer;
- gating of frog movement and one-cycle respawn commands to the frog controller.

All outputs are registered. Event inputs come from the collision/scene logic on the same clock.

## Interface
- c_LIVES, 3: lives granted at game start (1..3).
- c_DEATH_CYCLES, 25000000: length of the death pause, in clocks.
- c_GOAL_CYCLES, 12500000: length of the goal pause, in clocks.
- c_SECOND_CYCLES, 25000000: clocks per timer second.
- c_ROUND_SECONDS, 30: round timer reload value (1..63).
- c_SCORE_MAX, 99: score saturation value.
- c_BLINK_BIT, 22: bit of the pause counter driving o_Blink.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst_L, input, 1: reset, asynchronous, active-low.
- i_Start, input, 1: start button level. The rising edge is detected internally.
- i_Collided, input, 1: frog hit by a car (level, sampled in PLAY).
- i_In_Water, input, 1: frog on a water tile and not on a log (level, sampled in PLAY).
- i_Goal, input, 1: frog reached a free goal tile (level, sampled in PLAY).
- o_State, output, 3: 0 IDLE, 1 PLAY, 2 DEATH, 3 GOAL, 4 OVER.
- o_Move_En, output, 1: frog controller may accept moves.
- o_Respawn, output, 1: one-cycle pulse; frog controller returns the frog to (10,14).
- o_Lives, output, 2: remaining lives.
- o_Score, output, 7: current score.
- o_Time_Left, output, 6: seconds remaining in the round.
- o_Blink, output, 1: frog sprite blink enable.
- o_Game_Over, output, 1: high in OVER.

## Operation
- Reset values:
  - o_State = IDLE; o_Move_En = 0; o_Respawn = 0; o_Lives = 0; o_Score = 0; o_Time_Left = 0; o_Blink = 0; o_Game_Over = 0.
  - Pause counter = 0; start edge register = 0.
- Start edge: i_Start is high this cycle and was low last cycle. The edge is ignored outside IDLE/OVER.
- IDLE or OVER, on start edge:
  - o_Lives = c_LIVES; o_Score = 0; o_Time_Left = c_ROUND_SECONDS; o_Respawn pulses.
  - Go to PLAY.
- PLAY: o_Move_En = 1. Event priority, highest first:
  1. Death: i_Collided, i_In_Water or timer expiry.
     - o_Lives decrements (it never wraps below 0).
     - Pause counter clears. Go to DEATH.
  2. i_Goal:
     - o_Score increments, saturating at c_SCORE_MAX.
     - Pause counter clears. Go to GOAL.
  - If death and goal occur in the same cycle, death wins and the score is unchanged.
- DEATH:
  - o_Move_En = 0. Counter increments each clock. o_Blink = counter[c_BLINK_BIT].
  - When counter = c_DEATH_CYCLES-1:
    - If o_Lives = 0, go to OVER. No respawn.
    - Otherwise pulse o_Respawn, reload o_Time_Left and go to PLAY.
- GOAL:
  - o_Move_En = 0; o_Blink = 0.
  - When counter = c_GOAL_CYCLES-1: pulse o_Respawn, reload o_Time_Left and go to PLAY.
- OVER: o_Game_Over = 1; o_Move_En = 0. o_Score and o_Lives (0) hold.
- Event inputs are ignored in every state except PLAY.
- The pause counter is 25 bits wide. Parameters must keep c_*_CYCLES below 2^25.

## Timing
- Event sampled at edge N: the new o_State, o_Lives and o_Score are visible after edge N. o_Move_En drops after the same edge.
- o_Respawn is high for exactly the one cycle following the transition edge into PLAY. o_State already reads PLAY in that cycle.
- DEATH lasts exactly c_DEATH_CYCLES clocks and GOAL lasts exactly c_GOAL_CYCLES clocks (entry edge to exit edge).
- Start edge detection adds 1 cycle: a rise at edge N enters PLAY at edge N+1.
- Reset asserted mid-game forces all outputs to their reset values immediately (asynchronously), with no respawn pulse.

## Configuration
- FROGGER_ROUND_TIMER_EN defined:
  - A 25-bit second counter runs only in PLAY and clears on every entry to PLAY.
  - At c_SECOND_CYCLES-1 it wraps and o_Time_Left decrements.
  - When o_Time_Left reaches 0 (in PLAY), a death is raised in the next cycle with the same priority as a collision.
- FROGGER_ROUND_TIMER_EN undefined:
  - No second counter is built; o_Time_Left is held at 0.
  - Timer expiry never occurs.

## Test plan
Bench parameters: c_DEATH_CYCLES = 8, c_GOAL_CYCLES = 4, c_SECOND_CYCLES = 10, c_ROUND_SECONDS = 3, c_BLINK_BIT = 1.
- Reset, then start edge -> o_State = 1 and o_Lives = 3 one cycle later; one o_Respawn pulse; o_Time_Left = 3.
- i_Goal for 1 cycle in PLAY -> o_Score = 1; GOAL for 4 clocks; then PLAY with o_Respawn pulse. A goal at score 99 keeps o_Score = 99.
- i_Collided and i_Goal together -> o_Lives = 2, o_Score unchanged, DEATH for 8 clocks with o_Blink toggling every 2 clocks, then respawn.
- Three deaths in a row -> after the third DEATH, o_State = 4, o_Game_Over = 1, no respawn. A later start edge restarts with o_Lives = 3 and o_Score = 0.
- Timer enabled, idle frog -> o_Time_Left counts 3, 2, 1, 0 every 10 clocks, then DEATH. Timer disabled -> o_Time_Left stays 0 and no death occurs.
- Drop i_Rst_L during DEATH -> o_State = 0 and all outputs reset asynchronously. Events are ignored until a start edge.
